// File: rtl/editor_hora_bcd.sv
// BCD HH:MM:SS time source: counts on tick_1hz in RUN, field editing with
// push-button pulses in EDIT, with one-cycle EN/ACT load strobes downstream.
module editor_hora_bcd #(
  parameter int MODO_24H = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       seleccion,
  input  logic       btn_der,
  input  logic       btn_izq,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  output logic [7:0] dseg,
  output logic [7:0] dmin,
  output logic [7:0] dhora,
  output logic       EN,
  output logic       ACT,
  output logic [1:0] campo
);

  typedef enum logic [0:0] {RUN = 1'b0, EDIT = 1'b1} state_t;

  localparam logic [7:0] HORA_RST = (MODO_24H != 0) ? 8'h00 : 8'h12;

  state_t     state_r, state_s;
  logic [7:0] dseg_r, dseg_s;
  logic [7:0] dmin_r, dmin_s;
  logic [7:0] dhora_r, dhora_s;
  logic [1:0] campo_r, campo_s;
  logic       en_r, en_s;
  logic       act_r, act_s;

  // Minutes/seconds increment 00..59, nibble-wise BCD.
  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) inc60 = 8'h00;
      else                inc60 = {v[7:4] + 4'd1, 4'd0};
    end else begin
      inc60 = {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  function automatic logic [7:0] dec60(input logic [7:0] v);
    if (v[3:0] == 4'd0) begin
      if (v[7:4] == 4'd0) dec60 = 8'h59;
      else                dec60 = {v[7:4] - 4'd1, 4'd9};
    end else begin
      dec60 = {v[7:4], v[3:0] - 4'd1};
    end
  endfunction

  // Hours wrap 23->00 in 24h mode, 12->01 in 12h mode.
  function automatic logic [7:0] inc_hora(input logic [7:0] v);
    if ((MODO_24H != 0) && (v == 8'h23))      inc_hora = 8'h00;
    else if ((MODO_24H == 0) && (v == 8'h12)) inc_hora = 8'h01;
    else if (v[3:0] == 4'd9)                  inc_hora = {v[7:4] + 4'd1, 4'd0};
    else                                      inc_hora = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] dec_hora(input logic [7:0] v);
    if ((MODO_24H != 0) && (v == 8'h00))      dec_hora = 8'h23;
    else if ((MODO_24H == 0) && (v == 8'h01)) dec_hora = 8'h12;
    else if (v[3:0] == 4'd0)                  dec_hora = {v[7:4] - 4'd1, 4'd9};
    else                                      dec_hora = {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Next-state and next-output logic, interpreted per the registered mode.
  always_comb begin
    state_s = seleccion ? EDIT : RUN;
    dseg_s  = dseg_r;
    dmin_s  = dmin_r;
    dhora_s = dhora_r;
    campo_s = campo_r;
    en_s    = 1'b0;
    act_s   = 1'b0;
    case (state_r)
      RUN: begin
        if (tick_1hz) begin
          dseg_s = inc60(dseg_r);
          if (dseg_r == 8'h59) begin
            dmin_s = inc60(dmin_r);
            if (dmin_r == 8'h59) dhora_s = inc_hora(dhora_r);
            else                 dhora_s = dhora_r;
          end else begin
            dmin_s = dmin_r;
          end
          en_s = 1'b1;
        end else begin
          en_s = 1'b0;
        end
        if (seleccion) campo_s = 2'b00;
        else           campo_s = campo_r;
      end
      EDIT: begin
        // Exactly one of up/down edits the field under the old cursor.
        if (btn_arriba ^ btn_abajo) begin
          case (campo_r)
            2'b00: begin
              dseg_s = btn_arriba ? inc60(dseg_r) : dec60(dseg_r);
              act_s  = 1'b1;
            end
            2'b01: begin
              dmin_s = btn_arriba ? inc60(dmin_r) : dec60(dmin_r);
              act_s  = 1'b1;
            end
            2'b10: begin
              dhora_s = btn_arriba ? inc_hora(dhora_r) : dec_hora(dhora_r);
              act_s   = 1'b1;
            end
            default: act_s = 1'b0;
          endcase
        end else begin
          act_s = 1'b0;
        end
        if (btn_der && !btn_izq)
          campo_s = (campo_r == 2'b10) ? 2'b00 : campo_r + 2'd1;
        else if (btn_izq && !btn_der)
          campo_s = (campo_r == 2'b00) ? 2'b10 : campo_r - 2'd1;
        else
          campo_s = campo_r;
      end
      default: state_s = RUN;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
      dseg_r  <= 8'h00;
      dmin_r  <= 8'h00;
      dhora_r <= HORA_RST;
      campo_r <= 2'b00;
      en_r    <= 1'b0;
      act_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      dseg_r  <= dseg_s;
      dmin_r  <= dmin_s;
      dhora_r <= dhora_s;
      campo_r <= campo_s;
      en_r    <= en_s;
      act_r   <= act_s;
    end
  end

  assign dseg  = dseg_r;
  assign dmin  = dmin_r;
  assign dhora = dhora_r;
  assign campo = campo_r;
  assign EN    = en_r;
  assign ACT   = act_r;

endmodule

// File: tb/tb_editor_hora_bcd.sv
// Bench for editor_hora_bcd: 24h and 12h instances checked every cycle against
// an integer time model, plus hand-computed literal checks.
module tb_editor_hora_bcd;

  logic clk = 1'b0;
  logic reset, tick, sel, der, izq, up, dn_a, dn_b;
  logic [7:0] dseg_a, dmin_a, dhora_a, dseg_b, dmin_b, dhora_b;
  logic [1:0] campo_a, campo_b;
  logic en_a, act_a, en_b, act_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  editor_hora_bcd #(.MODO_24H(1)) u24 (
    .clk(clk), .reset(reset), .tick_1hz(tick), .seleccion(sel),
    .btn_der(der), .btn_izq(izq), .btn_arriba(up), .btn_abajo(dn_a),
    .dseg(dseg_a), .dmin(dmin_a), .dhora(dhora_a), .EN(en_a), .ACT(act_a),
    .campo(campo_a));

  editor_hora_bcd #(.MODO_24H(0)) u12 (
    .clk(clk), .reset(reset), .tick_1hz(tick), .seleccion(sel),
    .btn_der(der), .btn_izq(izq), .btn_arriba(up), .btn_abajo(dn_b),
    .dseg(dseg_b), .dmin(dmin_b), .dhora(dhora_b), .EN(en_b), .ACT(act_b),
    .campo(campo_b));

  // Model state, index 0 = 24h instance, 1 = 12h instance; plain integers.
  int ms[2], mm[2], mh[2], mc[2];
  bit medit[2], men[2], mact[2];
  bit mvalid = 1'b0;

  function automatic logic [7:0] bcd(input int v);
    bcd = 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int hinc(input int h, input bit m24);
    if (m24) hinc = (h + 1) % 24;
    else     hinc = (h == 12) ? 1 : h + 1;
  endfunction

  function automatic int hdec(input int h, input bit m24);
    if (m24) hdec = (h + 23) % 24;
    else     hdec = (h == 1) ? 12 : h - 1;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic bit m24 = (k == 0);
      automatic bit dn  = (k == 0) ? dn_a : dn_b;
      automatic int s = ms[k], m = mm[k], h = mh[k], c = mc[k];
      automatic bit en = 1'b0, ac = 1'b0, ed = medit[k];
      if (reset) begin
        s = 0; m = 0; h = m24 ? 0 : 12; c = 0; ed = 1'b0;
      end else begin
        if (!ed) begin
          if (tick) begin
            s = s + 1;
            if (s == 60) begin
              s = 0; m = m + 1;
              if (m == 60) begin m = 0; h = hinc(h, m24); end
            end
            en = 1'b1;
          end
          if (sel) c = 0;
        end else begin
          if (up != dn) begin
            if (c == 0)      s = up ? (s + 1) % 60 : (s + 59) % 60;
            else if (c == 1) m = up ? (m + 1) % 60 : (m + 59) % 60;
            else             h = up ? hinc(h, m24) : hdec(h, m24);
            ac = 1'b1;
          end
          if (der && !izq)      c = (c + 1) % 3;
          else if (izq && !der) c = (c + 2) % 3;
        end
        ed = sel;
      end
      ms[k] <= s; mm[k] <= m; mh[k] <= h; mc[k] <= c;
      medit[k] <= ed; men[k] <= en; mact[k] <= ac;
    end
    if (reset) mvalid <= 1'b1;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("m24_seg", dseg_a, bcd(ms[0]));
      chk("m24_min", dmin_a, bcd(mm[0]));
      chk("m24_hora", dhora_a, bcd(mh[0]));
      chk("m24_campo", {6'd0, campo_a}, 8'(mc[0]));
      chk("m24_en_act", {6'd0, en_a, act_a}, {6'd0, men[0], mact[0]});
      chk("m12_seg", dseg_b, bcd(ms[1]));
      chk("m12_min", dmin_b, bcd(mm[1]));
      chk("m12_hora", dhora_b, bcd(mh[1]));
      chk("m12_campo", {6'd0, campo_b}, 8'(mc[1]));
      chk("m12_en_act", {6'd0, en_b, act_b}, {6'd0, men[1], mact[1]});
    end
  end

  task automatic step(input bit t, input bit s, input bit d, input bit i,
                      input bit u, input bit da, input bit db);
    tick = t; sel = s; der = d; izq = i; up = u; dn_a = da; dn_b = db;
    @(posedge clk);
    #2;
    tick = 1'b0; der = 1'b0; izq = 1'b0; up = 1'b0; dn_a = 1'b0; dn_b = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; sel = 1'b0; der = 1'b0; izq = 1'b0;
    up = 1'b0; dn_a = 1'b0; dn_b = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_seg", dseg_a, 8'h00);
    chk("rst_hora24", dhora_a, 8'h00);
    chk("rst_hora12", dhora_b, 8'h12);
    chk("rst_strobes", {6'd0, en_a, act_a}, 8'h00);
    reset = 1'b0;

    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      chk("tick_seg", dseg_a, 8'(i));
      chk("tick_en", {7'd0, en_a}, 8'h01);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("idle_en", {7'd0, en_a}, 8'h00);
    end

    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1);
    chk("dn_wrap_seg", dseg_a, 8'h59);
    chk("dn_wrap_min", dmin_a, 8'h00);
    chk("dn_act", {7'd0, act_a}, 8'h01);
    step(0, 1, 0, 0, 1, 0, 0);
    chk("up_wrap_seg", dseg_a, 8'h00);
    chk("up_wrap_min", dmin_a, 8'h00);

    step(0, 1, 1, 0, 0, 0, 0); chk("der1", {6'd0, campo_a}, 8'h01);
    step(0, 1, 1, 0, 0, 0, 0); chk("der2", {6'd0, campo_a}, 8'h02);
    step(0, 1, 1, 0, 0, 0, 0); chk("der3", {6'd0, campo_a}, 8'h00);
    step(0, 1, 0, 1, 0, 0, 0); chk("izq1", {6'd0, campo_a}, 8'h02);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0); chk("izq3", {6'd0, campo_a}, 8'h00);
    step(0, 1, 1, 0, 1, 0, 0);
    chk("updr_seg", dseg_a, 8'h01);
    chk("updr_campo", {6'd0, campo_a}, 8'h01);

    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("frozen_seg", dseg_a, 8'h01);
    chk("frozen_en", {7'd0, en_a}, 8'h00);
    step(0, 1, 0, 0, 1, 1, 1);
    chk("updn_min", dmin_a, 8'h00);
    chk("updn_act", {7'd0, act_a}, 8'h00);

    // Preload 23:59:59 (24h) and 12:59:59 (12h), then one tick in RUN.
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 1, 1);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    chk("pre_seg", dseg_a, 8'h59);
    chk("pre_hora24", dhora_a, 8'h23);
    chk("pre_hora12", dhora_b, 8'h12);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("exit_en", {7'd0, en_a}, 8'h00);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("roll_seg", dseg_a, 8'h00);
    chk("roll_min", dmin_a, 8'h00);
    chk("roll_hora24", dhora_a, 8'h00);
    chk("roll_hora12", dhora_b, 8'h01);
    chk("roll_en", {6'd0, en_a, en_b}, 8'h03);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("roll_en_off", {6'd0, en_a, en_b}, 8'h00);

    // Edit to 10:20:30, then reset with a coincident tick and button.
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 1, 0, 0);
    chk("ed_seg", dseg_a, 8'h30);
    chk("ed_min", dmin_a, 8'h20);
    chk("ed_hora", dhora_a, 8'h10);
    chk("ed_hora12", dhora_b, 8'h11);
    reset = 1'b1;
    step(1, 0, 0, 0, 1, 0, 0);
    chk("rr_seg", dseg_a, 8'h00);
    chk("rr_min", dmin_a, 8'h00);
    chk("rr_hora", dhora_a, 8'h00);
    chk("rr_campo", {6'd0, campo_a}, 8'h00);
    chk("rr_strobes", {6'd0, en_a, act_a}, 8'h00);
    reset = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rr_run_seg", dseg_a, 8'h01);
    chk("rr_run_en", {7'd0, en_a}, 8'h01);
    step(0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
